// File: rtl/key_frame_sync_debounce.sv
// Debounces active-low keys into one-hot press flags, released at vsync frame start (or 1 cycle after confirm).
// Press confirm lands 2+CNT_MAX cycles after key_in falls; flag and key_state are registered; no backpressure.
module key_frame_sync_debounce #(
   parameter int   KEY_NUM    = 4,
   parameter int   CNT_MAX    = 500000,
   parameter logic VS_ACTIVE  = 1'b0,
   parameter bit   FRAME_SYNC = 1'b1
) (
   input  logic               vga_clk,
   input  logic               sys_rst_n,
   input  logic [KEY_NUM-1:0] key_in,
   input  logic               vsync_in,
   output logic [KEY_NUM-1:0] key_flag,
   output logic [KEY_NUM-1:0] key_state
);

   localparam int            CW       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_FILT = 2'd1,
      HELD       = 2'd2,
      REL_FILT   = 2'd3
   } key_fsm_t;

   logic [KEY_NUM-1:0] key_m;
   logic [KEY_NUM-1:0] key_s;

   key_fsm_t           state     [KEY_NUM];
   key_fsm_t           state_nxt [KEY_NUM];
   logic [CW-1:0]      cnt       [KEY_NUM];
   logic [CW-1:0]      cnt_nxt   [KEY_NUM];
   logic [KEY_NUM-1:0] confirm;
   logic [KEY_NUM-1:0] held;

   logic               vsync_d;
   logic               frame_start;
   logic [KEY_NUM-1:0] pending;
   logic [KEY_NUM-1:0] pending_nxt;
   logic [KEY_NUM-1:0] sel_src;
   logic [KEY_NUM-1:0] sel;

   // Released keys idle high, so the synchronizer resets to 1 to avoid a false press.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         key_m <= '1;
         key_s <= '1;
      end else begin
         key_m <= key_in;
         key_s <= key_m;
      end
   end

   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         for (int i = 0; i < KEY_NUM; i++) begin
            state[i] <= IDLE;
            cnt[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < KEY_NUM; i++) begin
            state[i] <= state_nxt[i];
            cnt[i]   <= cnt_nxt[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < KEY_NUM; i++) begin
         state_nxt[i] = state[i];
         cnt_nxt[i]   = cnt[i];
         confirm[i]   = 1'b0;
         held[i]      = 1'b0;
         unique case (state[i])
            IDLE: begin
               if (!key_s[i]) begin
                  state_nxt[i] = PRESS_FILT;
                  cnt_nxt[i]   = '0;
               end
            end
            PRESS_FILT: begin
               if (key_s[i]) begin
                  state_nxt[i] = IDLE;
                  cnt_nxt[i]   = '0;
               end else if (cnt[i] == CNT_LAST) begin
                  state_nxt[i] = HELD;
                  cnt_nxt[i]   = '0;
                  confirm[i]   = 1'b1;
               end else begin
                  cnt_nxt[i]   = cnt[i] + 1'b1;
               end
            end
            HELD: begin
               held[i] = 1'b1;
               if (key_s[i]) begin
                  state_nxt[i] = REL_FILT;
                  cnt_nxt[i]   = '0;
               end
            end
            REL_FILT: begin
               held[i] = 1'b1;
               if (!key_s[i]) begin
                  state_nxt[i] = HELD;
                  cnt_nxt[i]   = '0;
               end else if (cnt[i] == CNT_LAST) begin
                  state_nxt[i] = IDLE;
                  cnt_nxt[i]   = '0;
               end else begin
                  cnt_nxt[i]   = cnt[i] + 1'b1;
               end
            end
            default: begin
               state_nxt[i] = IDLE;
               cnt_nxt[i]   = '0;
            end
         endcase
      end
   end

   assign frame_start = (vsync_d != VS_ACTIVE) && (vsync_in == VS_ACTIVE);

   // Frame-synced mode only looks at pending bits from earlier cycles; a set on the
   // same bit as the clear wins so a coincident press waits for the next frame.
   always_comb begin
      sel_src     = '0;
      pending_nxt = pending;
      if (FRAME_SYNC) begin
         sel_src = frame_start ? pending : '0;
      end else begin
         sel_src = pending | confirm;
      end
      sel = sel_src & (~sel_src + KEY_NUM'(1));
      if (FRAME_SYNC) begin
         pending_nxt = (pending & ~sel) | confirm;
      end else begin
         pending_nxt = sel_src & ~sel;
      end
   end

   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         vsync_d   <= ~VS_ACTIVE;
         pending   <= '0;
         key_flag  <= '0;
         key_state <= '0;
      end else begin
         vsync_d   <= vsync_in;
         pending   <= pending_nxt;
         key_flag  <= sel;
         key_state <= held;
      end
   end

endmodule

// File: doc/key_frame_sync_debounce.md
Name: key_frame_sync_debounce

Overview:
Upstream control stage for the display-mode selector. It debounces four active-low push-buttons and turns each confirmed press into a single-cycle key flag. Flags are deferred to the next frame-start edge of the VGA vsync, so the selector's mode counter only advances between frames and never tears a frame. It also exports debounced key levels for status LEDs.

Parameters:
KEY_NUM, 4, number of buttons handled.
CNT_MAX, 500000, stable cycles required to confirm a press or release (20 ms at 25 MHz).
VS_ACTIVE, 1'b0, vsync active level; frame start is the transition into this level.
FRAME_SYNC, 1, 1 = flags deferred to frame start; 0 = flag issued 1 cycle after press confirm.

Ports:
vga_clk  in  1  pixel clock; all logic on its rising edge
sys_rst_n  in  1  asynchronous, active-low reset
key_in  in  KEY_NUM  raw buttons, 0 = pressed, asynchronous to vga_clk
vsync_in  in  1  vsync from the timing generator, synchronous to vga_clk
key_flag  out  KEY_NUM  single-cycle press pulses; at most one bit high per cycle
key_state  out  KEY_NUM  debounced level, 1 = held

Behaviour:
- Reset: sys_rst_n is asynchronous, active-low; clock is vga_clk. While reset is asserted:
  - synchronizer flops = all 1;
  - every key FSM = IDLE with count 0;
  - pending = 0, vsync_d = ~VS_ACTIVE;
  - key_flag = 0, key_state = 0.
- Reset deasserted mid-press: the key restarts from IDLE and needs a full CNT_MAX filter.
- Synchronizer: 2-flop per key. key_s is the second-stage output.
- Per-key FSM (counter width = clog2(CNT_MAX)):
  - IDLE: key_s=0 -> PRESS_FILT, cnt=0.
  - PRESS_FILT: key_s=1 -> IDLE, cnt=0. Otherwise cnt+1. At cnt==CNT_MAX-1 -> HELD and assert confirm[i] for 1 cycle.
  - HELD: key_s=1 -> REL_FILT, cnt=0.
  - REL_FILT: key_s=0 -> HELD, cnt=0. Otherwise cnt+1. At cnt==CNT_MAX-1 -> IDLE.
  - key_state[i] = 1 in HELD and REL_FILT, registered from FSM state.
  - Holding a key never produces a second confirm; release and re-press are required.
- Press latency: key_in low at edge 0 -> key_s low at edge 2 -> confirm at edge 2+CNT_MAX.
- Pending register (FRAME_SYNC=1):
  - confirm[i] sets pending[i]; a repeat confirm while pending[i]=1 merges (no queueing).
  - frame_start = (vsync_d != VS_ACTIVE) && (vsync_in == VS_ACTIVE); vsync_d is vsync_in registered.
  - On frame_start: select the lowest-index set bit of the pending value held before this cycle's update. Pulse that bit on key_flag in the next cycle and clear that pending bit. Other pending bits wait for later frames, one flag per frame.
  - confirm and clear on the same bit in the same cycle: set wins; the new press is flagged at the following frame.
  - No pending bits at frame_start: key_flag stays 0.
- FRAME_SYNC=0: key_flag = confirm registered (1-cycle latency), no pending state. If several confirms coincide, the lowest index goes out now and the others go out on following cycles, still one-hot.
- key_flag is registered, one-hot or zero, and exactly 1 cycle wide.

Test Plan:
All cases use CNT_MAX=16, FRAME_SYNC=1, VS_ACTIVE=0, vsync period 200 cycles with the low pulse starting at cycle 100.
- Clean press: key_in[0] low at cycle 10 and held -> key_state[0]=1 at cycle ~28; key_flag=4'b0001 for exactly 1 cycle at cycle 101; no further flags while held; release -> key_state[0]=0 ~18 cycles later.
- Bounce: key_in[1] toggles every 5 cycles for 60 cycles, then rests high -> no key_flag, key_state[1] stays 0; the FSM returns to IDLE.
- Multi-key: keys 0 and 2 confirmed before cycle 100 -> 4'b0001 at 101, 4'b0100 at 301, nothing at 501.
- Confirm coincident with frame_start (press timed so confirm lands on cycle 100) -> no flag at 101; 4'b0001 at 301.
- Reset mid-filter: sys_rst_n low for 3 cycles while key_in[3] is low at cnt=10 -> all outputs 0 immediately; after release the key needs 16 more stable cycles plus 2 sync cycles to confirm.
- FRAME_SYNC=0: same clean press -> key_flag=4'b0001 one cycle after confirm, independent of vsync.
